ula_ex_stage: RTL and testbench

// Execute-stage wrapper that feeds the team's ula (2-bit op: 00 SUB, 01 ADD, 10 EQU, 11 SLT; outputs result, v).

---
 rtl/ula_ex_stage.sv | 176 +++++++++++++++++
 tb/tb_ula_ex_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ula_ex_stage.sv
// rtl/ula_ex_stage.sv - execute stage: funct decode, S1 operand register, ula, S2 output register
// Two-deep valid/ready pipeline around the combinational ula; keeps sticky overflow and a transfer counter.

module ula #(
  parameter int BITS = 63
) (
  input  logic [1:0]    op_i,
  input  logic [BITS:0] a_i,
  input  logic [BITS:0] b_i,
  output logic [BITS:0] result_o,
  output logic          v_o
);

  logic [BITS:0] sum;
  logic [BITS:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_o = '0;
    v_o      = 1'b0;
    case (op_i)
      2'b00: begin
        result_o = diff;
        v_o      = (a_i[BITS] != b_i[BITS]) && (diff[BITS] != a_i[BITS]);
      end
      2'b01: begin
        result_o = sum;
        v_o      = (a_i[BITS] == b_i[BITS]) && (sum[BITS] != a_i[BITS]);
      end
      2'b10:   result_o = {{BITS{1'b0}}, (a_i == b_i)};
      default: result_o = {{BITS{1'b0}}, ($signed(a_i) < $signed(b_i))};
    endcase
  end

endmodule

module ula_ex_stage #(
  parameter int BITS  = 63,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS:0]    in_a,
  input  logic [BITS:0]    in_b,
  input  logic [2:0]       in_funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS:0]    out_result,
  output logic             out_v,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_illegal,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [BITS:0]    a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             ill_q, ill_d;
  logic             out_valid_q, out_valid_d;
  logic [BITS:0]    result_q, result_d;
  logic             v_q, v_d;
  logic             illegal_q, illegal_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_ready, accept, move, xfer;
  logic [1:0]       dec_op;
  logic [BITS:0]    ula_result;
  logic             ula_v;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  assign accept   = in_valid && in_ready;
  assign move     = s1_valid_q && s2_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    dec_op = 2'b01;
    case (in_funct[1:0])
      2'b00:   dec_op = 2'b01;
      2'b01:   dec_op = 2'b00;
      2'b10:   dec_op = 2'b10;
      default: dec_op = 2'b11;
    endcase
  end

  ula #(.BITS(BITS)) u_ula (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (ula_result),
    .v_o      (ula_v)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    v_d         = v_q;
    illegal_d   = illegal_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q + CNT_W'(xfer);

    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      b_d        = in_b;
      op_d       = dec_op;
      ill_d      = in_funct[2];
    end else if (move) begin
      s1_valid_d = 1'b0;
    end

    // Illegal ops still flow through S2 with a zero result; v only means something for ADD/SUB.
    if (move) begin
      out_valid_d = 1'b1;
      result_d    = ill_q ? '0 : ula_result;
      v_d         = !ill_q && !op_q[1] && ula_v;
      illegal_d   = ill_q;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end

    if (xfer && v_q)     sticky_d = 1'b1;
    else if (clr_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      v_q         <= 1'b0;
      illegal_q   <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      v_q         <= v_d;
      illegal_q   <= illegal_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = result_q;
  assign out_v       = v_q;
  assign out_zero    = (result_q == '0);
  assign out_neg     = result_q[BITS];
  assign out_illegal = illegal_q;
  assign ovf_sticky  = sticky_q;
  assign op_count    = cnt_q;

endmodule

// File: tb/tb_ula_ex_stage.sv
// tb/tb_ula_ex_stage.sv - directed-vector bench for ula_ex_stage (default and 4-bit counter instances)
module tb_ula_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;
  logic [2:0]  in_funct = 3'b000;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;

  logic        in_ready, out_valid, out_v, out_zero, out_neg, out_illegal, ovf_sticky;
  logic [63:0] out_result;
  logic [15:0] op_count;

  logic        in_ready4, out_valid4, out_v4, out_zero4, out_neg4, out_illegal4, ovf_sticky4;
  logic [63:0] out_result4;
  logic [3:0]  op_count4;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [63:0] held;

  always #5 clock = ~clock;

  ula_ex_stage #(.BITS(63), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_funct(in_funct), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_v(out_v), .out_zero(out_zero),
    .out_neg(out_neg), .out_illegal(out_illegal), .clr_sticky(clr_sticky),
    .ovf_sticky(ovf_sticky), .op_count(op_count)
  );

  ula_ex_stage #(.BITS(63), .CNT_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_funct(in_funct), .out_valid(out_valid4),
    .out_ready(out_ready), .out_result(out_result4), .out_v(out_v4), .out_zero(out_zero4),
    .out_neg(out_neg4), .out_illegal(out_illegal4), .clr_sticky(clr_sticky),
    .ovf_sticky(ovf_sticky4), .op_count(op_count4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One unstalled operation: accept, move to S2, check outputs, transfer.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_r, input logic exp_v,
                        input logic exp_z, input logic exp_n, input logic exp_il);
    logic [3:0] c4;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_funct  = f;
    in_a      = a;
    in_b      = b;
    check({tag, ".in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, ".lat1_valid"}, out_valid, 0);
    step();
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".result"}, out_result, exp_r);
    check({tag, ".v"}, out_v, exp_v);
    check({tag, ".zero"}, out_zero, exp_z);
    check({tag, ".neg"}, out_neg, exp_n);
    check({tag, ".illegal"}, out_illegal, exp_il);
    step();
    exp_cnt++;
    c4 = exp_cnt[3:0];
    check({tag, ".op_count"}, op_count, exp_cnt[15:0]);
    check({tag, ".op_count4"}, op_count4, c4);
  endtask

  initial begin
    step();
    step();
    reset_n = 1'b1;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.result", out_result, 0);
    check("rst.sticky", ovf_sticky, 0);
    check("rst.op_count", op_count, 0);

    run_op("add", 3'b000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 0, 0, 0, 0);
    check("add.sticky", ovf_sticky, 0);

    run_op("add_ovf", 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1, 0, 1, 0);
    check("add_ovf.sticky", ovf_sticky, 1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr.sticky", ovf_sticky, 0);

    run_op("sub_ovf", 3'b001, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
    run_op("slt", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0, 0, 0, 0);
    run_op("slt_f", 3'b011, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1, 0, 0);
    run_op("equ", 3'b010, 64'h1234, 64'h1234, 64'd1, 0, 0, 0, 0);
    run_op("equ_f", 3'b010, 64'h1234, 64'h1235, 64'd0, 0, 1, 0, 0);
    run_op("sub_eq", 3'b001, 64'd9, 64'd9, 64'd0, 0, 1, 0, 0);
    run_op("sub_neg", 3'b001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 0);
    run_op("ill", 3'b101, 64'd7, 64'd9, 64'd0, 0, 1, 0, 1);
    run_op("ill_ovf", 3'b100, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1, 0, 1);

    // Backpressure: three back-to-back items with the output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_funct  = 3'b000;
    in_a = 64'd1; in_b = 64'd1;
    check("bp.rdy0", in_ready, 1);
    step();
    in_a = 64'd2; in_b = 64'd2;
    check("bp.rdy1", in_ready, 1);
    step();
    in_a = 64'd3; in_b = 64'd3;
    check("bp.rdy2_full", in_ready, 0);
    check("bp.head", out_result, 64'd2);
    held = out_result;
    step();
    step();
    check("bp.stall_rdy", in_ready, 0);
    check("bp.stall_valid", out_valid, 1);
    check("bp.stall_result", out_result, held);
    out_ready = 1'b1;
    #1;
    check("bp.comb_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp.second", out_result, 64'd4);
    check("bp.second_valid", out_valid, 1);
    step();
    check("bp.third", out_result, 64'd6);
    check("bp.third_valid", out_valid, 1);
    step();
    check("bp.drained", out_valid, 0);
    exp_cnt += 3;
    check("bp.op_count", op_count, exp_cnt[15:0]);

    // Reset with both stages full and sticky set.
    run_op("pre_rst", 3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1, 0, 1, 0);
    check("pre_rst.sticky", ovf_sticky, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 64'd10; in_b = 64'd20;
    step();
    step();
    in_valid = 1'b0;
    check("full.rdy", in_ready, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_cnt = 0;
    check("rst2.out_valid", out_valid, 0);
    check("rst2.sticky", ovf_sticky, 0);
    check("rst2.op_count", op_count, 0);
    check("rst2.op_count4", op_count4, 0);
    check("rst2.in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    step();
    check("rst2.discarded", out_valid, 0);

    for (int i = 0; i < 16; i++) begin
      run_op("wrap", 3'b000, 64'(i), 64'(i), 64'(2 * i), 0, (i == 0), 0, 0);
    end
    check("wrap.op_count4", op_count4, 0);
    check("wrap.op_count", op_count, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
